// File: rtl/vga_plot_sched.sv
// vga_plot_sched: merges single-pixel CPU writes and a row-major rectangle-fill engine into one
// registered plot stream via a two-way round-robin arbiter. Optional macro PLOT_SCHED_CLIP_EN
// suppresses the plot strobe for granted pixels that fall outside H_RES x V_RES.

module vga_plot_sched #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        CLOCK_50,
    input  logic [0:0]  KEY,

    input  logic        cpu_req,
    input  logic [9:0]  cpu_x,
    input  logic [8:0]  cpu_y,
    input  logic [23:0] cpu_color,
    output logic        cpu_ack,

    input  logic        fill_start,
    input  logic [9:0]  fill_x0,
    input  logic [8:0]  fill_y0,
    input  logic [9:0]  fill_w,
    input  logic [8:0]  fill_h,
    input  logic [23:0] fill_color,
    output logic        fill_busy,
    output logic        fill_done,

    output logic [9:0]  VGA_X,
    output logic [8:0]  VGA_Y,
    output logic [23:0] VGA_COLOR,
    output logic        plot
);

`ifdef PLOT_SCHED_CLIP_EN
    localparam int XW = 11;
    localparam int YW = 10;
`else
    localparam int XW = 10;
    localparam int YW = 9;
`endif

    if (H_RES < 1 || H_RES > 1024 || V_RES < 1 || V_RES > 512) begin : g_bad_res
        $error("vga_plot_sched: H_RES/V_RES must fit the 10/9-bit coordinate ports");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    logic        rst_n;
    assign rst_n = KEY[0];

    state_t      state_q, state_d;
    logic [9:0]  x0_q, x0_d;
    logic [8:0]  y0_q, y0_d;
    logic [9:0]  w_q, w_d;
    logic [8:0]  h_q, h_d;
    logic [23:0] color_q, color_d;
    logic [9:0]  x_cnt_q, x_cnt_d;
    logic [8:0]  y_cnt_q, y_cnt_d;
    logic        last_fill_q, last_fill_d;
    logic        plot_q, plot_d;
    logic [9:0]  vga_x_q, vga_x_d;
    logic [8:0]  vga_y_q, vga_y_d;
    logic [23:0] vga_color_q, vga_color_d;

    logic          fill_pend;
    logic          cpu_grant;
    logic          fill_grant;
    logic [XW-1:0] fill_px_x;
    logic [YW-1:0] fill_px_y;
    logic [XW-1:0] sel_x;
    logic [YW-1:0] sel_y;
    logic [23:0]   sel_color;
    logic          in_range;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            last_fill_q <= 1'b1;
            plot_q      <= 1'b0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            w_q         <= w_d;
            h_q         <= h_d;
            color_q     <= color_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            last_fill_q <= last_fill_d;
            plot_q      <= plot_d;
            vga_x_q     <= vga_x_d;
            vga_y_q     <= vga_y_d;
            vga_color_q <= vga_color_d;
        end
    end

    // On a tie the requester that did not win last time is served, so contention alternates.
    always_comb begin
        fill_pend  = (state_q == S_FILL);
        cpu_grant  = cpu_req && (!fill_pend || last_fill_q);
        fill_grant = fill_pend && !cpu_grant;
    end

    always_comb begin
        fill_px_x = XW'(x0_q) + XW'(x_cnt_q);
        fill_px_y = YW'(y0_q) + YW'(y_cnt_q);
        if (cpu_grant) begin
            sel_x     = XW'(cpu_x);
            sel_y     = YW'(cpu_y);
            sel_color = cpu_color;
        end else begin
            sel_x     = fill_px_x;
            sel_y     = fill_px_y;
            sel_color = color_q;
        end
`ifdef PLOT_SCHED_CLIP_EN
        in_range = (int'(sel_x) < H_RES) && (int'(sel_y) < V_RES);
`else
        in_range = 1'b1;
`endif
    end

    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        w_d         = w_q;
        h_d         = h_q;
        color_d     = color_q;
        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        last_fill_d = last_fill_q;
        plot_d      = 1'b0;
        vga_x_d     = vga_x_q;
        vga_y_d     = vga_y_q;
        vga_color_d = vga_color_q;

        case (state_q)
            S_IDLE: begin
                if (fill_start) begin
                    x0_d    = fill_x0;
                    y0_d    = fill_y0;
                    w_d     = fill_w;
                    h_d     = fill_h;
                    color_d = fill_color;
                    x_cnt_d = '0;
                    y_cnt_d = '0;
                    if (fill_w == 10'd0 || fill_h == 9'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (fill_grant) begin
                    if (x_cnt_q == w_q - 10'd1) begin
                        x_cnt_d = '0;
                        if (y_cnt_q == h_q - 9'd1) begin
                            state_d = S_DONE;
                        end else begin
                            y_cnt_d = y_cnt_q + 9'd1;
                        end
                    end else begin
                        x_cnt_d = x_cnt_q + 10'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cpu_grant || fill_grant) begin
            last_fill_d = fill_grant;
        end

        // Clipped grants still consume their slot, but leave the output registers untouched.
        if ((cpu_grant || fill_grant) && in_range) begin
            plot_d      = 1'b1;
            vga_x_d     = sel_x[9:0];
            vga_y_d     = sel_y[8:0];
            vga_color_d = sel_color;
        end
    end

    assign cpu_ack   = cpu_grant && rst_n;
    assign fill_busy = (state_q != S_IDLE);
    assign fill_done = (state_q == S_DONE);
    assign plot      = plot_q;
    assign VGA_X     = vga_x_q;
    assign VGA_Y     = vga_y_q;
    assign VGA_COLOR = vga_color_q;

endmodule
